// File: rtl/fft_frame_tx.sv
// Buffers one frame of FFT bins from the core stream and replays it as a strobe-led,
// bubble-free burst of N_BINS {re,im} words toward the spectrum display capture RAM.
module fft_frame_tx #(
    parameter int unsigned N_BINS   = 256,
    parameter int unsigned GAP_CYC  = 16,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic        fft_clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        fft_data_valid,
    output logic [31:0] fft_data_out,
    output logic        burst_active,
    output logic [15:0] frame_cnt,
    output logic        short_frame,
    output logic        overrun
);
    localparam int unsigned AW = $clog2(N_BINS);
    localparam int unsigned GW = $clog2(GAP_CYC + 1) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_BINS - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYC);

    typedef enum logic [2:0] {
        S_FILL,
        S_ZFILL,
        S_DRAIN,
        S_GAP,
        S_START,
        S_BURST,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wr_ptr, wr_ptr_nx;
    logic [AW-1:0] rd_ptr, rd_ptr_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic          first, first_nx;
    logic          armed;
    logic [15:0]   frame_cnt_nx;
    logic          short_nx, overrun_nx;
    logic          hs;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   mem [N_BINS];

    always_ff @(posedge fft_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // armed holds s_ready low for the first cycle after reset release
    assign s_ready        = armed && (state == S_FILL || state == S_DRAIN);
    assign hs             = s_valid && s_ready;
    assign fft_data_valid = (state == S_START);
    assign burst_active   = (state == S_BURST);
    assign fft_data_out   = burst_active ? rd_data : '0;

    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            gap_cnt     <= '0;
            first       <= 1'b1;
            armed       <= 1'b0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            rd_ptr      <= rd_ptr_nx;
            gap_cnt     <= gap_cnt_nx;
            first       <= first_nx;
            armed       <= 1'b1;
            frame_cnt   <= frame_cnt_nx;
            short_frame <= short_nx;
            overrun     <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        wr_ptr_nx    = wr_ptr;
        rd_ptr_nx    = rd_ptr;
        first_nx     = first;
        frame_cnt_nx = frame_cnt;
        short_nx     = short_frame;
        overrun_nx   = overrun;
        gap_cnt_nx   = (gap_cnt < GAP_MAX) ? gap_cnt + 1'b1 : gap_cnt;
        wr_en        = 1'b0;
        wr_addr      = wr_ptr;
        wr_data      = s_data;
        rd_en        = 1'b0;
        rd_addr      = rd_ptr;

        case (state)
            S_FILL: begin
                if (hs) begin
                    wr_en     = 1'b1;
                    wr_ptr_nx = wr_ptr + 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        state_nx = s_last ? S_GAP : S_DRAIN;
                    end else if (s_last) begin
                        short_nx = 1'b1;
                        state_nx = S_ZFILL;
                    end
                end
            end
            S_ZFILL: begin
                wr_en     = 1'b1;
                wr_data   = '0;
                wr_ptr_nx = wr_ptr + 1'b1;
                if (wr_ptr == LAST_ADDR) state_nx = S_GAP;
            end
            S_DRAIN: begin
                if (hs) begin
                    overrun_nx = 1'b1;
                    if (s_last) state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (first || gap_cnt >= GAP_MAX) state_nx = S_START;
            end
            S_START: begin
                rd_en     = 1'b1;
                rd_addr   = '0;
                rd_ptr_nx = '0;
                state_nx  = S_BURST;
            end
            S_BURST: begin
                // read one word ahead so rd_data always holds word rd_ptr
                rd_en     = (rd_ptr != LAST_ADDR);
                rd_addr   = rd_ptr + 1'b1;
                rd_ptr_nx = rd_ptr + 1'b1;
                if (rd_ptr == LAST_ADDR) begin
                    frame_cnt_nx = frame_cnt + 1'b1;
                    gap_cnt_nx   = '0;
                    wr_ptr_nx    = '0;
                    first_nx     = 1'b0;
                    state_nx     = ONE_SHOT ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: state_nx = S_FILL;
        endcase
    end
endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx: full, short, overrun, back-to-back, mid-burst reset
// and one-shot frames, each checked against ramp words computed here.
module tb_fft_frame_tx;
    localparam int unsigned N   = 256;
    localparam int unsigned GAP = 16;
    localparam int unsigned N1  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n;
    logic [31:0] s_data;
    logic        s_valid, s_last;
    logic        s_ready, fft_data_valid, burst_active, short_frame, overrun;
    logic [31:0] fft_data_out;
    logic [15:0] frame_cnt;
    logic        s_ready1, valid1, active1, short1, over1;
    logic [31:0] data1;
    logic [15:0] cnt1;

    fft_frame_tx #(.N_BINS(N), .GAP_CYC(GAP), .ONE_SHOT(1'b0)) dut (
        .fft_clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .fft_data_valid(fft_data_valid), .fft_data_out(fft_data_out),
        .burst_active(burst_active), .frame_cnt(frame_cnt), .short_frame(short_frame),
        .overrun(overrun)
    );

    fft_frame_tx #(.N_BINS(N1), .GAP_CYC(4), .ONE_SHOT(1'b1)) dut1 (
        .fft_clk(clk), .rst_n(rst1_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready1), .fft_data_valid(valid1), .fft_data_out(data1),
        .burst_active(active1), .frame_cnt(cnt1), .short_frame(short1), .overrun(over1)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cap [N];
    int          cap_cyc [N];
    int          cap_n = 0, strobe_cyc = 0, last_end = 0, gap_seen = 0;
    int          bursts = 0, strobes = 0, rdy_viol = 0;
    logic [31:0] cap1 [N1];
    int          cap1_n = 0, bursts1 = 0, strobes1 = 0;

    always @(negedge clk) begin
        if (s_ready && (fft_data_valid || burst_active)) rdy_viol++;
        if (fft_data_valid) begin
            gap_seen   = cyc - last_end;
            strobe_cyc = cyc;
            cap_n      = 0;
            strobes++;
        end
        if (burst_active) begin
            if (cap_n < N) begin
                cap[cap_n]     = fft_data_out;
                cap_cyc[cap_n] = cyc;
            end
            cap_n++;
            last_end = cyc;
            if (cap_n == N) bursts++;
        end
        if (valid1) begin
            cap1_n = 0;
            strobes1++;
        end
        if (active1) begin
            if (cap1_n < N1) cap1[cap1_n] = data1;
            cap1_n++;
            if (cap1_n == N1) bursts1++;
        end
    end

    function automatic logic [31:0] exp_word(input int k, input bit inv);
        logic [15:0] a;
        a = k[15:0];
        return inv ? {~a, a} : {a, ~a};
    endfunction

    // number of captured words differing from the ramp, zeros past valid_words
    function automatic int burst_errors(input bit inv, input int valid_words);
        int e = 0;
        for (int k = 0; k < N; k++) begin
            if (cap[k] !== ((k < valid_words) ? exp_word(k, inv) : 32'h0)) e++;
        end
        return e;
    endfunction

    function automatic int timing_errors();
        int e = 0;
        for (int k = 0; k < N; k++) begin
            if (cap_cyc[k] - strobe_cyc != k + 1) e++;
        end
        return e;
    endfunction

    task automatic send_frame(input int n, input int last_at, input bit inv, input bit to1);
        int t;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = exp_word(k, inv);
            s_last  = (k == last_at);
            t = 0;
            while (((to1 ? s_ready1 : s_ready) !== 1'b1) && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) begin
                checks++;
                $display("FAIL send_timeout word %0d: s_ready stayed low, required high", k);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        int t = 0;
        while (bursts < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bursts < target) $display("FAIL burst_timeout: bursts %0d, required %0d", bursts, target);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, fft_data_valid, burst_active, short_frame, overrun} !== 5'b0)
            $display("FAIL reset_ctrl: {rdy,strb,act,short,ovr}=%b, required 00000",
                     {s_ready, fft_data_valid, burst_active, short_frame, overrun});
        else passed++;
        checks++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: %0d, required 0", frame_cnt);
        else passed++;
        checks++;
        if (fft_data_out !== 32'h0) $display("FAIL reset_data: %h, required 0", fft_data_out);
        else passed++;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready_after: %b, required 1", s_ready);
        else passed++;
    endtask

    task automatic test_full_frame();
        int e;
        send_frame(256, 255, 1'b0, 1'b0);
        wait_bursts(1);
        checks++;
        if (cap_n !== 256) $display("FAIL full_len: %0d words, required 256", cap_n);
        else passed++;
        e = burst_errors(1'b0, 256);
        checks++;
        if (e !== 0) $display("FAIL full_data: %0d bad words (w0=%h), required 0 (w0=%h)", e, cap[0], exp_word(0, 1'b0));
        else passed++;
        e = timing_errors();
        checks++;
        if (e !== 0) $display("FAIL full_timing: %0d late words (w0 at +%0d), required 0 (+1)", e, cap_cyc[0] - strobe_cyc);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL full_frame_cnt: %0d, required 1", frame_cnt);
        else passed++;
        checks++;
        if ({short_frame, overrun} !== 2'b00) $display("FAIL full_flags: %b, required 00", {short_frame, overrun});
        else passed++;
        checks++;
        if ({burst_active, fft_data_out} !== 33'h0) $display("FAIL full_idle: act=%b data=%h, required 0/0", burst_active, fft_data_out);
        else passed++;
    endtask

    task automatic test_short_frame();
        int e;
        send_frame(100, 99, 1'b0, 1'b0);
        wait_bursts(2);
        e = burst_errors(1'b0, 100);
        checks++;
        if (e !== 0) $display("FAIL short_data: %0d bad words (w100=%h), required 0 (w100=0)", e, cap[100]);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd2) $display("FAIL short_frame_cnt: %0d, required 2", frame_cnt);
        else passed++;
        checks++;
        if ({short_frame, overrun} !== 2'b10) $display("FAIL short_flags: %b, required 10", {short_frame, overrun});
        else passed++;
    endtask

    task automatic test_overrun();
        int e;
        send_frame(300, 299, 1'b0, 1'b0);
        wait_bursts(3);
        e = burst_errors(1'b0, 256);
        checks++;
        if (e !== 0) $display("FAIL over_data: %0d bad words (w255=%h), required 0 (w255=%h)", e, cap[255], exp_word(255, 1'b0));
        else passed++;
        checks++;
        if (frame_cnt !== 16'd3) $display("FAIL over_frame_cnt: %0d, required 3", frame_cnt);
        else passed++;
        checks++;
        if ({short_frame, overrun} !== 2'b11) $display("FAIL over_flags: %b, required 11", {short_frame, overrun});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int e;
        send_frame(256, 255, 1'b1, 1'b0);
        send_frame(256, 255, 1'b0, 1'b0);
        wait_bursts(5);
        e = burst_errors(1'b0, 256);
        checks++;
        if (e !== 0) $display("FAIL b2b_data: %0d bad words, required 0", e);
        else passed++;
        checks++;
        if (gap_seen <= int'(GAP)) $display("FAIL b2b_gap: %0d cycles, required > %0d", gap_seen, GAP);
        else passed++;
        checks++;
        if (rdy_viol !== 0) $display("FAIL b2b_ready_low: %0d ready cycles in burst, required 0", rdy_viol);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd5) $display("FAIL b2b_frame_cnt: %0d, required 5", frame_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int s0, b0, t, e;
        s0 = strobes;
        send_frame(256, 255, 1'b0, 1'b0);
        t = 0;
        while (!(strobes > s0 && cap_n >= 128) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) $display("FAIL mid_wait: cap_n %0d, required 128", cap_n);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({burst_active, fft_data_valid} !== 2'b00) $display("FAIL mid_active: %b, required 00", {burst_active, fft_data_valid});
        else passed++;
        checks++;
        if (fft_data_out !== 32'h0) $display("FAIL mid_data: %h, required 0", fft_data_out);
        else passed++;
        checks++;
        if ({frame_cnt, short_frame, overrun} !== 18'h0) $display("FAIL mid_cnt_flags: cnt=%0d flags=%b, required 0/00", frame_cnt, {short_frame, overrun});
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        b0 = bursts;
        send_frame(256, 255, 1'b1, 1'b0);
        wait_bursts(b0 + 1);
        e = burst_errors(1'b1, 256);
        checks++;
        if (e !== 0) $display("FAIL mid_new_data: %0d bad words (w0=%h), required 0 (w0=%h)", e, cap[0], exp_word(0, 1'b1));
        else passed++;
        e = timing_errors();
        checks++;
        if (e !== 0) $display("FAIL mid_new_timing: %0d late words, required 0", e);
        else passed++;
        checks++;
        if (frame_cnt !== 16'd1) $display("FAIL mid_frame_cnt: %0d, required 1", frame_cnt);
        else passed++;
    endtask

    task automatic test_one_shot();
        int t, e, highs;
        @(posedge clk); #1 rst1_n = 1'b1;
        send_frame(16, 15, 1'b0, 1'b1);
        t = 0;
        while (bursts1 < 1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            s_valid = 1'b1;
            s_data  = exp_word(k, 1'b1);
            s_last  = ((k % 16) == 15);
            @(negedge clk);
            if (s_ready1 !== 1'b0) highs++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (4) @(negedge clk);
        e = 0;
        for (int k = 0; k < int'(N1); k++) if (cap1[k] !== exp_word(k, 1'b0)) e++;
        checks++;
        if (e !== 0) $display("FAIL os_data: %0d bad words (w0=%h), required 0 (w0=%h)", e, cap1[0], exp_word(0, 1'b0));
        else passed++;
        checks++;
        if (strobes1 !== 1) $display("FAIL os_strobes: %0d, required 1", strobes1);
        else passed++;
        checks++;
        if (cnt1 !== 16'd1) $display("FAIL os_frame_cnt: %0d, required 1", cnt1);
        else passed++;
        checks++;
        if (highs !== 0) $display("FAIL os_ready_low: %0d ready cycles after burst, required 0", highs);
        else passed++;
        checks++;
        if ({active1, valid1, data1} !== 34'h0) $display("FAIL os_idle: act=%b strb=%b data=%h, required 0", active1, valid1, data1);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_overrun();
        test_back_to_back();
        test_reset_mid_burst();
        test_one_shot();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
